// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core with one shared memory port
// for instructions and data.
//
// Supported instructions: lw, sw, add, sub, and, or, slt, beq, addi, j
// (plus bne when MULTICYCLE_BNE_EN is defined). Any other opcode or R-type
// funct parks the core in ILLEGAL until reset.
//
// Optional feature macro: MULTICYCLE_BNE_EN
//   defined   -> opcode 0x05 (bne) branches when A != B
//   undefined -> opcode 0x05 is illegal
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   mem_req     memory request (FETCH, MEMREAD, MEMWRITE only)
//   mem_we      1 = write, 0 = read
//   mem_addr    byte address (pc in FETCH, ALUOut otherwise)
//   mem_wdata   store data (B register)
//   mem_rdata   read data, sampled only when mem_ready=1
//   mem_ready   completes the current request in the cycle it is high
//   pc          current PC register
//   state       current FSM state encoding (debug)
//   illegal     high while halted on an unsupported instruction
//
// Memory handshake: mem_req acts as valid and mem_ready as ready. While
// mem_req=1 the core holds mem_we/mem_addr/mem_wdata stable; the request
// completes in the first cycle where mem_req and mem_ready are both high.
module mips_multicycle_core #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc,
    output logic [3:0]       state,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t           st;
    logic [WIDTH-1:0] pc_q;
    logic [31:0]      ir;
    logic [WIDTH-1:0] a_q, b_q, alu_out, data_q;
    logic [WIDTH-1:0] rf [32];

    logic [5:0]       op, funct;
    logic [4:0]       rs, rt, rd;
    logic [WIDTH-1:0] sign_imm;
    logic [WIDTH-1:0] rf_a, rf_b;
    logic [WIDTH-1:0] r_result;
    logic             r_ok;
    logic             take;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sign_imm = {{(WIDTH-16){ir[15]}}, ir[15:0]};

    // Register 0 is never written, but gate the read so it is zero by design.
    assign rf_a = (rs == 5'd0) ? '0 : rf[rs];
    assign rf_b = (rt == 5'd0) ? '0 : rf[rt];

    // R-type ALU; r_ok drops for unsupported funct codes.
    always_comb begin
        r_result = '0;
        r_ok     = 1'b1;
        case (funct)
            6'h20:   r_result = a_q + b_q;
            6'h22:   r_result = a_q - b_q;
            6'h24:   r_result = a_q & b_q;
            6'h25:   r_result = a_q | b_q;
            6'h2A:   r_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: r_ok = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_BNE_EN
    assign take = (op == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
    assign take = (a_q == b_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_FETCH;
            pc_q    <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            data_q  <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir   <= mem_rdata[31:0];
                        pc_q <= pc_q + WIDTH'(4);
                        st   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rf_a;
                    b_q     <= rf_b;
                    // Branch target precomputed from the already-incremented pc.
                    alu_out <= pc_q + (sign_imm << 2);
                    case (op)
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_RTYPE:     st <= S_EXECUTE;
                        OP_BEQ:       st <= S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
                        OP_BNE:       st <= S_BRANCH;
`endif
                        OP_ADDI:      st <= S_ADDIEX;
                        OP_J:         st <= S_JUMP;
                        default:      st <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    alu_out <= a_q + sign_imm;
                    st      <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    if (mem_ready) begin
                        data_q <= mem_rdata;
                        st     <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    if (rt != 5'd0) rf[rt] <= data_q;
                    st <= S_FETCH;
                end
                S_MEMWRITE: begin
                    if (mem_ready) st <= S_FETCH;
                end
                S_EXECUTE: begin
                    if (r_ok) begin
                        alu_out <= r_result;
                        st      <= S_ALUWB;
                    end else begin
                        st <= S_ILLEGAL;
                    end
                end
                S_ALUWB: begin
                    if (rd != 5'd0) rf[rd] <= alu_out;
                    st <= S_FETCH;
                end
                S_BRANCH: begin
                    if (take) pc_q <= alu_out;
                    st <= S_FETCH;
                end
                S_ADDIEX: begin
                    alu_out <= a_q + sign_imm;
                    st      <= S_ADDIWB;
                end
                S_ADDIWB: begin
                    if (rt != 5'd0) rf[rt] <= alu_out;
                    st <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q <= {pc_q[WIDTH-1:28], ir[25:0], 2'b00};
                    st   <= S_FETCH;
                end
                S_ILLEGAL: st <= S_ILLEGAL;
                default:   st <= S_ILLEGAL;
            endcase
        end
    end

    assign mem_req   = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
    assign mem_we    = (st == S_MEMWRITE);
    assign mem_addr  = (st == S_FETCH) ? pc_q : alu_out;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign state     = st;
    assign illegal   = (st == S_ILLEGAL);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Testbench for mips_multicycle_core (WIDTH=32, RESET_PC=0).
// Memory model: 512 words, single-cycle everywhere except the window
// 0x40..0x7F, where every access waits 3 cycles with mem_ready low.
// Register contents are observed through stores, checked against exp_q.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  state;

    mips_multicycle_core #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .state(state), .illegal(illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [0:511];
    int          wait_cnt = 0;
    logic        slow;

    assign mem_rdata = mem[mem_addr[10:2]];
    assign slow      = (mem_addr >= 32'h40) && (mem_addr < 32'h80);
    assign mem_ready = mem_req && (!slow || (wait_cnt >= 3));

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // A write completes at the next rising edge when req/we/ready are all high.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_we && mem_ready) begin
            logic [63:0] e;
            mem[mem_addr[10:2]] = mem_wdata;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL store_unexpected: got addr %h data %h, required no store",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("store", {mem_addr, mem_wdata}, e);
            end
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    localparam logic [31:0] SPIN = 32'h1000FFFF;  // beq $0,$0,-1

    // ---------------- driver tasks ----------------
    task automatic begin_test;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    endtask

    task automatic release_rst;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fetch(input logic [31:0] addr, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state == 4'd0 && pc == addr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_reached"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_reached"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  funct;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          waits;
        int          cycles;
        int          bad;
        int          writes_before;

        vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 6'h20, 32'h80000000};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 6'h20, 32'h00000000};
        vecs[2] = '{32'h00000005, 32'h00000007, 6'h22, 32'hFFFFFFFE};
        vecs[3] = '{32'h00000000, 32'h00000001, 6'h22, 32'hFFFFFFFF};
        vecs[4] = '{32'hF0F0F0F0, 32'h0FF00FF0, 6'h24, 32'h00F000F0};
        vecs[5] = '{32'hF0F0F0F0, 32'h0F0F0000, 6'h25, 32'hFFFFF0F0};
        vecs[6] = '{32'h80000000, 32'h00000001, 6'h2A, 32'h00000001};
        vecs[7] = '{32'h00000001, 32'h80000000, 6'h2A, 32'h00000000};
        vecs[8] = '{32'h12345678, 32'h12345678, 6'h2A, 32'h00000000};

        // ---- reset state ----
        begin_test();
        mem[0] = SPIN;
        release_rst();
        check("rst_state",     {60'd0, state}, 64'd0);
        check("rst_pc",        {32'd0, pc}, 64'd0);
        check("rst_mem_req",   {63'd0, mem_req}, 64'd1);
        check("rst_mem_we",    {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);
        check("rst_illegal",   {63'd0, illegal}, 64'd0);

        // ---- addi timing, beq not taken, writes to $0 discarded ----
        begin_test();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);      // addi $1,$0,5
        mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h80);     // sw $1,0x80
        mem[2] = enc_i(6'h04, 5'd1, 5'd0, 16'd5);      // beq $1,$0,+5 (not taken)
        mem[3] = enc_i(6'h2B, 5'd0, 5'd1, 16'h84);     // sw $1,0x84
        mem[4] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);      // addi $0,$0,9
        mem[5] = enc_i(6'h2B, 5'd0, 5'd0, 16'h88);     // sw $0,0x88
        mem[6] = SPIN;
        exp_q.push_back({32'h80, 32'd5});
        exp_q.push_back({32'h84, 32'd5});
        exp_q.push_back({32'h88, 32'd0});
        release_rst();
        repeat (4) @(negedge clk);
        check("addi_pc",    {32'd0, pc}, 64'd4);
        check("addi_state", {60'd0, state}, 64'd0);
        drain("addi", 100);

        // ---- R-type table ----
        for (int i = 0; i < 9; i++) begin
            begin_test();
            mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h200);  // lw $1,0x200
            mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h204);  // lw $2,0x204
            mem[2] = enc_r(5'd1, 5'd2, 5'd3, vecs[i].funct);
            mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h80);   // sw $3,0x80
            mem[4] = SPIN;
            mem[9'h80] = vecs[i].a;
            mem[9'h81] = vecs[i].b;
            exp_q.push_back({32'h80, vecs[i].exp});
            release_rst();
            drain($sformatf("vec%0d", i), 100);
        end

        // ---- add overflow wraps, then signed slt on the result ----
        begin_test();
        mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h200);
        mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h204);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);       // add $3,$1,$2
        mem[3] = enc_r(5'd3, 5'd1, 5'd4, 6'h2A);       // slt $4,$3,$1
        mem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'h80);
        mem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h84);
        mem[6] = SPIN;
        mem[9'h80] = 32'h7FFFFFFF;
        mem[9'h81] = 32'h00000001;
        exp_q.push_back({32'h80, 32'h80000000});
        exp_q.push_back({32'h84, 32'h00000001});
        release_rst();
        drain("add_slt", 150);

        // ---- sw/lw to the slow window: stable outputs, lw takes 8 cycles ----
        begin_test();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h1234);   // addi $1,$0,0x1234
        mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h40);     // sw $1,0x40
        mem[2] = enc_i(6'h23, 5'd0, 5'd2, 16'h40);     // lw $2,0x40
        mem[3] = enc_i(6'h2B, 5'd0, 5'd2, 16'h80);     // sw $2,0x80
        mem[4] = SPIN;
        exp_q.push_back({32'h40, 32'h1234});
        exp_q.push_back({32'h80, 32'h1234});
        release_rst();
        wait_fetch(32'h4, 20, "sw_fetch");
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state == 4'd0) break;
            if (mem_req && mem_we && !mem_ready) begin
                waits++;
                check("sw_wait_addr",  {32'd0, mem_addr}, 64'h40);
                check("sw_wait_wdata", {32'd0, mem_wdata}, 64'h1234);
            end
        end
        check("sw_wait_cycles", 64'(waits), 64'd3);
        wait_fetch(32'h8, 20, "lw_fetch");
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cycles++;
            if (state == 4'd0) break;
        end
        check("lw_cycles", 64'(cycles), 64'd8);
        drain("sw_lw", 100);

        // ---- jumps and a taken beq ----
        begin_test();
        mem[0]      = enc_j(26'h100);                  // j 0x100 -> 0x400
        mem[9'h100] = enc_j(26'h4);                    // j 4     -> 0x10
        mem[4]      = SPIN;                            // beq $0,$0,-1 at 0x10
        release_rst();
        repeat (3) @(negedge clk);
        check("j_pc",       {32'd0, pc}, 64'h400);
        check("j_state",    {60'd0, state}, 64'd0);
        repeat (3) @(negedge clk);
        check("j2_pc",      {32'd0, pc}, 64'h10);
        repeat (1) @(negedge clk);
        check("beq_pc_inc", {32'd0, pc}, 64'h14);
        repeat (2) @(negedge clk);
        check("beq_pc",     {32'd0, pc}, 64'h10);
        check("beq_state",  {60'd0, state}, 64'd0);

        // ---- illegal opcode, frozen, recovered by reset ----
        begin_test();
        mem[0] = 32'hFC000000;                         // opcode 0x3F
        release_rst();
        repeat (2) @(negedge clk);
        check("ill_flag",    {63'd0, illegal}, 64'd1);
        check("ill_state",   {60'd0, state}, 64'd12);
        check("ill_mem_req", {63'd0, mem_req}, 64'd0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req || !illegal || pc != 32'h4) bad++;
        end
        check("ill_frozen", 64'(bad), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ill_rst_flag",    {63'd0, illegal}, 64'd0);
        check("ill_rst_mem_req", {63'd0, mem_req}, 64'd1);
        check("ill_rst_addr",    {32'd0, mem_addr}, 64'd0);

        // ---- illegal R-type funct ----
        begin_test();
        mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h00);       // funct 0x00 unsupported
        release_rst();
        repeat (3) @(negedge clk);
        check("ill_funct", {63'd0, illegal}, 64'd1);

        // ---- bne ----
        begin_test();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);      // addi $1,$0,1
        mem[1] = enc_i(6'h05, 5'd1, 5'd0, 16'd2);      // bne $1,$0,+2 -> 0x10
        mem[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h80);
        mem[3] = SPIN;
        mem[4] = enc_i(6'h2B, 5'd0, 5'd1, 16'h84);
        mem[5] = SPIN;
`ifdef MULTICYCLE_BNE_EN
        exp_q.push_back({32'h84, 32'd1});
`endif
        release_rst();
        wait_fetch(32'h4, 20, "bne_fetch");
`ifdef MULTICYCLE_BNE_EN
        repeat (3) @(negedge clk);
        check("bne_pc",    {32'd0, pc}, 64'h10);
        check("bne_state", {60'd0, state}, 64'd0);
        drain("bne", 100);
`else
        repeat (2) @(negedge clk);
        check("bne_illegal", {63'd0, illegal}, 64'd1);
        drain("bne", 20);
`endif

        // ---- reset during a stalled store ----
        begin_test();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);      // addi $1,$0,7
        mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h40);     // sw $1,0x40 (slow)
        mem[2] = SPIN;
        release_rst();
        wait_state(4'd5, 30, "mw");
        rst = 1'b1;
        writes_before = n_writes;
        mem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h80);     // dump $1
        mem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'h84);     // dump $2
        mem[2] = SPIN;
        exp_q.push_back({32'h80, 32'd0});
        exp_q.push_back({32'h84, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        check("mw_rst_state",  {60'd0, state}, 64'd0);
        check("mw_rst_req",    {63'd0, mem_req}, 64'd1);
        check("mw_rst_addr",   {32'd0, mem_addr}, 64'd0);
        check("mw_no_write",   64'(n_writes), 64'(writes_before));
        drain("mw", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
